// File: rtl/flow_state_store_np.sv
// Per-flow state store: NUM_RD_P backpressured read ports whose held responses
// track later writes, plus prioritised masked writers, with a post-reset init walk.
module flow_state_store_np #(
  parameter int unsigned          WIDTH_P    = 64,
  parameter int unsigned          ELS_P      = 64,
  parameter int unsigned          NUM_RD_P   = 2,
  parameter int unsigned          NUM_WR_P   = 2,
  parameter logic [WIDTH_P-1:0]   INIT_VAL_P = '0,
  localparam int unsigned         FLOWID_W   = $clog2(ELS_P)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           init_done,
  input  logic [NUM_RD_P-1:0]            rd_req_val,
  input  logic [NUM_RD_P*FLOWID_W-1:0]   rd_req_flowid,
  output logic [NUM_RD_P-1:0]            rd_req_rdy,
  output logic [NUM_RD_P-1:0]            rd_resp_val,
  output logic [NUM_RD_P*FLOWID_W-1:0]   rd_resp_flowid,
  output logic [NUM_RD_P*WIDTH_P-1:0]    rd_resp_data,
  input  logic [NUM_RD_P-1:0]            rd_resp_rdy,
  input  logic [NUM_WR_P-1:0]            wr_req_val,
  input  logic [NUM_WR_P*FLOWID_W-1:0]   wr_req_flowid,
  input  logic [NUM_WR_P*WIDTH_P-1:0]    wr_req_data,
  input  logic [NUM_WR_P*WIDTH_P-1:0]    wr_req_mask,
  output logic [NUM_WR_P-1:0]            wr_req_rdy,
  input  logic                           new_flow_val,
  input  logic [FLOWID_W-1:0]            new_flow_flowid,
  input  logic [WIDTH_P-1:0]             new_flow_data,
  output logic                           new_flow_rdy
);

  localparam int unsigned NUM_IDS = 1 << FLOWID_W;

  // Which encodable flowids map onto real entries (all of them when ELS_P is a power of 2).
  function automatic logic [NUM_IDS-1:0] mk_flow_ok();
    logic [NUM_IDS-1:0] ok;
    ok = '0;
    for (int unsigned i = 0; i < NUM_IDS; i++) ok[i] = (i < ELS_P);
    return ok;
  endfunction

  localparam logic [NUM_IDS-1:0] FLOW_OK = mk_flow_ok();

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                state;
  logic [FLOWID_W-1:0]   ptr;
  logic [WIDTH_P-1:0]    mem [ELS_P];

  logic                  c_val;
  logic                  c_en;
  logic [FLOWID_W-1:0]   c_addr;
  logic [WIDTH_P-1:0]    c_data;
  logic [WIDTH_P-1:0]    c_mask;

  // Init walk, then wait one cycle before opening the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      ptr       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + FLOWID_W'(1);
          if (ptr == FLOWID_W'(ELS_P - 1)) state <= ST_READY;
        end
        ST_READY: init_done <= 1'b1;
        default:  state <= ST_INIT;
      endcase
    end
  end

  // Single write winner per cycle: walker, else new_flow, else lowest-index writer.
  always_comb begin
    logic taken;
    c_val        = 1'b0;
    c_addr       = '0;
    c_data       = '0;
    c_mask       = '0;
    wr_req_rdy   = '0;
    new_flow_rdy = 1'b0;
    taken        = 1'b0;
    if (state == ST_INIT) begin
      c_val  = 1'b1;
      c_addr = ptr;
      c_data = INIT_VAL_P;
      c_mask = '1;
    end else if (init_done) begin
      new_flow_rdy = 1'b1;
      if (new_flow_val) begin
        c_val  = 1'b1;
        c_addr = new_flow_flowid;
        c_data = new_flow_data;
        c_mask = '1;
      end
      taken = new_flow_val;
      for (int unsigned i = 0; i < NUM_WR_P; i++) begin
        wr_req_rdy[i] = ~taken;
        if (!taken && wr_req_val[i]) begin
          c_val  = 1'b1;
          c_addr = wr_req_flowid[i*FLOWID_W +: FLOWID_W];
          c_data = wr_req_data[i*WIDTH_P +: WIDTH_P];
          c_mask = wr_req_mask[i*WIDTH_P +: WIDTH_P];
        end
        taken = taken | wr_req_val[i];
      end
    end
  end

  assign c_en = c_val & FLOW_OK[c_addr];

  always_ff @(posedge clk) begin
    if (c_en) mem[c_addr] <= (mem[c_addr] & ~c_mask) | (c_data & c_mask);
  end

  for (genvar g = 0; g < NUM_RD_P; g++) begin : g_rd
    logic                  val_q;
    logic [FLOWID_W-1:0]   id_q;
    logic [WIDTH_P-1:0]    data_q;
    logic [FLOWID_W-1:0]   req_id;
    logic [WIDTH_P-1:0]    mem_q;
    logic [WIDTH_P-1:0]    acc_d;
    logic [WIDTH_P-1:0]    hold_d;

    assign req_id = rd_req_flowid[g*FLOWID_W +: FLOWID_W];
    assign mem_q  = FLOW_OK[req_id] ? mem[req_id] : '0;
    // Same-cycle commits fold into both fresh and held response data.
    assign acc_d  = (c_en && c_addr == req_id) ? ((mem_q & ~c_mask) | (c_data & c_mask)) : mem_q;
    assign hold_d = (c_en && c_addr == id_q) ? ((data_q & ~c_mask) | (c_data & c_mask)) : data_q;

    assign rd_req_rdy[g]                             = init_done & (~val_q | rd_resp_rdy[g]);
    assign rd_resp_val[g]                            = val_q;
    assign rd_resp_flowid[g*FLOWID_W +: FLOWID_W]    = id_q;
    assign rd_resp_data[g*WIDTH_P +: WIDTH_P]        = data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        val_q  <= 1'b0;
        id_q   <= '0;
        data_q <= '0;
      end else if (rd_req_val[g] && rd_req_rdy[g]) begin
        val_q  <= 1'b1;
        id_q   <= req_id;
        data_q <= acc_d;
      end else begin
        if (rd_resp_rdy[g]) val_q <= 1'b0;
        data_q <= hold_d;
      end
    end
  end

endmodule

// File: tb/tb_flow_state_store_np.sv
// Bench for flow_state_store_np: table vectors, directed corner sequences and
// random traffic checked against a flow-indexed reference memory.
module tb_flow_state_store_np;

  localparam int unsigned W   = 64;
  localparam int unsigned ELS = 64;
  localparam int unsigned NR  = 2;
  localparam int unsigned NW  = 2;
  localparam int unsigned FW  = 6;
  localparam logic [W-1:0] INIT = '0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               init_done;
  logic [NR-1:0]      rd_req_val, rd_req_rdy, rd_resp_val, rd_resp_rdy;
  logic [NR*FW-1:0]   rd_req_flowid, rd_resp_flowid;
  logic [NR*W-1:0]    rd_resp_data;
  logic [NW-1:0]      wr_req_val, wr_req_rdy;
  logic [NW*FW-1:0]   wr_req_flowid;
  logic [NW*W-1:0]    wr_req_data, wr_req_mask;
  logic               new_flow_val, new_flow_rdy;
  logic [FW-1:0]      new_flow_flowid;
  logic [W-1:0]       new_flow_data;

  flow_state_store_np #(.WIDTH_P(W), .ELS_P(ELS), .NUM_RD_P(NR), .NUM_WR_P(NW), .INIT_VAL_P(INIT)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .rd_req_val(rd_req_val), .rd_req_flowid(rd_req_flowid), .rd_req_rdy(rd_req_rdy),
    .rd_resp_val(rd_resp_val), .rd_resp_flowid(rd_resp_flowid), .rd_resp_data(rd_resp_data),
    .rd_resp_rdy(rd_resp_rdy),
    .wr_req_val(wr_req_val), .wr_req_flowid(wr_req_flowid), .wr_req_data(wr_req_data),
    .wr_req_mask(wr_req_mask), .wr_req_rdy(wr_req_rdy),
    .new_flow_val(new_flow_val), .new_flow_flowid(new_flow_flowid), .new_flow_data(new_flow_data),
    .new_flow_rdy(new_flow_rdy)
  );

  // Reference: flow contents plus, per read port, whether a response is owed and for which flow.
  logic [W-1:0]  m_mem [ELS];
  logic [NR-1:0] m_val;
  logic [FW-1:0] m_flow [NR];
  int            m_cnt;
  logic          m_ready;
  int            errors = 0;
  int            checks = 0;

  typedef struct {
    int            port;   // 0..NW-1 masked writer, NW = new_flow
    logic [FW-1:0] flow;
    logic [W-1:0]  data;
    logic [W-1:0]  mask;
    logic [W-1:0]  exp;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rd_req_val    = '0;
    rd_req_flowid = '0;
    rd_resp_rdy   = '1;
    wr_req_val    = '0;
    wr_req_flowid = '0;
    wr_req_data   = '0;
    wr_req_mask   = '0;
    new_flow_val  = 1'b0;
    new_flow_flowid = '0;
    new_flow_data = '0;
  endtask

  task automatic rand_inputs();
    rd_req_val  = NR'($urandom);
    rd_resp_rdy = NR'($urandom) | NR'($urandom);
    wr_req_val  = NW'($urandom);
    for (int i = 0; i < int'(NR); i++) rd_req_flowid[i*FW +: FW] = FW'($urandom_range(0, 7));
    for (int i = 0; i < int'(NW); i++) begin
      wr_req_flowid[i*FW +: FW] = FW'($urandom_range(0, 7));
      wr_req_data[i*W +: W]     = {$urandom, $urandom};
      wr_req_mask[i*W +: W]     = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
    end
    new_flow_val    = ($urandom_range(0, 3) == 0);
    new_flow_flowid = FW'($urandom_range(0, 7));
    new_flow_data   = {$urandom, $urandom};
  endtask

  // One clock: check handshakes, advance the model by the spec's rules, check responses.
  task automatic cycle();
    logic [NR-1:0] exp_rrdy;
    logic [NW-1:0] exp_wrdy;
    logic [W-1:0]  d, m;
    int            a;
    #1;
    for (int i = 0; i < int'(NW); i++) begin
      exp_wrdy[i] = m_ready & ~new_flow_val;
      for (int j = 0; j < i; j++) if (wr_req_val[j]) exp_wrdy[i] = 1'b0;
    end
    for (int i = 0; i < int'(NR); i++) exp_rrdy[i] = m_ready & (~m_val[i] | rd_resp_rdy[i]);
    chk("new_flow_rdy", 64'(new_flow_rdy), 64'(m_ready));
    chk("wr_req_rdy", 64'(wr_req_rdy), 64'(exp_wrdy));
    chk("rd_req_rdy", 64'(rd_req_rdy), 64'(exp_rrdy));
    if (m_ready) begin
      if (new_flow_val) m_mem[new_flow_flowid] = new_flow_data;
      else begin
        for (int p = 0; p < int'(NW); p++) begin
          if (wr_req_val[p]) begin
            a = int'(wr_req_flowid[p*FW +: FW]);
            d = wr_req_data[p*W +: W];
            m = wr_req_mask[p*W +: W];
            m_mem[a] = (m_mem[a] & ~m) | (d & m);
            break;
          end
        end
      end
    end
    for (int i = 0; i < int'(NR); i++) begin
      if (rd_req_val[i] && exp_rrdy[i]) begin
        m_val[i]  = 1'b1;
        m_flow[i] = rd_req_flowid[i*FW +: FW];
      end else if (rd_resp_rdy[i]) begin
        m_val[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_cnt++;
    if (m_cnt >= int'(ELS) + 1) m_ready = 1'b1;
    chk("init_done", 64'(init_done), 64'(m_ready));
    chk("rd_resp_val", 64'(rd_resp_val), 64'(m_val));
    for (int i = 0; i < int'(NR); i++) begin
      if (m_val[i]) begin
        chk($sformatf("rd_resp_flowid[%0d]", i), 64'(rd_resp_flowid[i*FW +: FW]), 64'(m_flow[i]));
        chk($sformatf("rd_resp_data[%0d]", i), rd_resp_data[i*W +: W], m_mem[m_flow[i]]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_val   = '0;
    m_cnt   = 0;
    m_ready = 1'b0;
    for (int f = 0; f < int'(ELS); f++) m_mem[f] = INIT;
    for (int i = 0; i < int'(NR); i++) m_flow[i] = '0;
    chk("reset rd_resp_val", 64'(rd_resp_val), 64'(0));
    chk("reset init_done", 64'(init_done), 64'(0));
    chk("reset rdy", 64'({new_flow_rdy, wr_req_rdy, rd_req_rdy}), 64'(0));
  endtask

  initial begin
    vec_t tbl [6];
    tbl[0] = '{NW, 6'd10, 64'hDEAD_BEEF_0123_4567, 64'h0,                   64'hDEAD_BEEF_0123_4567};
    tbl[1] = '{1,  6'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000, 64'hDEAD_BEEF_FFFF_4567};
    tbl[2] = '{NW, 6'd11, 64'h0000_0000_0000_1234, 64'h0,                   64'h0000_0000_0000_1234};
    tbl[3] = '{0,  6'd11, 64'h0,                   64'h0000_0000_0000_00F0, 64'h0000_0000_0000_1204};
    tbl[4] = '{0,  6'd12, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'h0};
    tbl[5] = '{1,  6'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};

    rst = 1'b1;
    idle();
    do_reset();

    // Init walk with traffic present: ports closed, init_done after exactly ELS+1 cycles.
    for (int c = 0; c < int'(ELS) + 1; c++) begin
      rand_inputs();
      cycle();
    end
    idle();
    for (int f = 0; f < int'(ELS); f++) begin
      rd_req_val[0] = 1'b1;
      rd_req_flowid[0 +: FW] = FW'(f);
      cycle();
      chk("init value", rd_resp_data[0 +: W], INIT);
    end

    // Table: one write, then read it back on port 1.
    for (int k = 0; k < 6; k++) begin
      idle();
      if (tbl[k].port == int'(NW)) begin
        new_flow_val    = 1'b1;
        new_flow_flowid = tbl[k].flow;
        new_flow_data   = tbl[k].data;
      end else begin
        wr_req_val[tbl[k].port]              = 1'b1;
        wr_req_flowid[tbl[k].port*FW +: FW]  = tbl[k].flow;
        wr_req_data[tbl[k].port*W +: W]      = tbl[k].data;
        wr_req_mask[tbl[k].port*W +: W]      = tbl[k].mask;
      end
      cycle();
      idle();
      rd_req_val[1] = 1'b1;
      rd_req_flowid[FW +: FW] = tbl[k].flow;
      cycle();
      chk($sformatf("table[%0d]", k), rd_resp_data[W +: W], tbl[k].exp);
    end

    // new_flow beats wr0 on the same flow; wr0 lands the cycle after.
    idle();
    new_flow_val = 1'b1; new_flow_flowid = 6'd5; new_flow_data = 64'hAA;
    wr_req_val[0] = 1'b1; wr_req_flowid[0 +: FW] = 6'd5;
    wr_req_data[0 +: W] = 64'h5500; wr_req_mask[0 +: W] = 64'hFF00;
    #1;
    chk("priority new_flow_rdy", 64'(new_flow_rdy), 64'(1));
    chk("priority wr0 blocked", 64'(wr_req_rdy[0]), 64'(0));
    cycle();
    new_flow_val = 1'b0;
    cycle();
    idle();
    rd_req_val[0] = 1'b1; rd_req_flowid[0 +: FW] = 6'd5;
    cycle();
    chk("wr0 after new_flow", rd_resp_data[0 +: W], 64'h55AA);

    // Write-first: read flow 3 in the same cycle wr1 updates its low byte.
    idle();
    new_flow_val = 1'b1; new_flow_flowid = 6'd3; new_flow_data = 64'h3456;
    cycle();
    idle();
    rd_req_val[0] = 1'b1; rd_req_flowid[0 +: FW] = 6'd3;
    wr_req_val[1] = 1'b1; wr_req_flowid[FW +: FW] = 6'd3;
    wr_req_data[W +: W] = 64'h12; wr_req_mask[W +: W] = 64'hFF;
    cycle();
    chk("write-first", rd_resp_data[0 +: W], 64'h3412);

    // Both ports stream flow 9, one response per cycle each.
    idle();
    new_flow_val = 1'b1; new_flow_flowid = 6'd9; new_flow_data = 64'h9999_0000_9999;
    cycle();
    idle();
    rd_req_val = '1; rd_req_flowid = {6'd9, 6'd9};
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("stream val", 64'(rd_resp_val), 64'(2'b11));
      chk("stream port0", rd_resp_data[0 +: W], 64'h9999_0000_9999);
      chk("stream port1", rd_resp_data[W +: W], 64'h9999_0000_9999);
    end

    // Held response on flow 7 absorbs a masked write.
    idle();
    new_flow_val = 1'b1; new_flow_flowid = 6'd7; new_flow_data = 64'h1111_1111_1111_1111;
    cycle();
    idle();
    rd_resp_rdy[0] = 1'b0;
    rd_req_val[0] = 1'b1; rd_req_flowid[0 +: FW] = 6'd7;
    cycle();
    rd_req_val[0] = 1'b0;
    wr_req_val[0] = 1'b1; wr_req_flowid[0 +: FW] = 6'd7;
    wr_req_data[0 +: W] = 64'hFFFF; wr_req_mask[0 +: W] = 64'h00F0;
    cycle();
    chk("held merge", rd_resp_data[0 +: W], 64'h1111_1111_1111_11F1);
    wr_req_val[0] = 1'b0;
    cycle();
    chk("held stable", rd_resp_data[0 +: W], 64'h1111_1111_1111_11F1);

    // Reset while a response is held, then a full walk under traffic.
    do_reset();
    for (int c = 0; c < int'(ELS) + 1; c++) begin
      rand_inputs();
      cycle();
    end

    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      cycle();
    end
    idle();
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
